sram_uart_loader: RTL
=====================

SRAM_UART_LOADER -- requirements
Module: sram_uart_loader

Interface
REQ-001 Parameter CLK_DIV, default 217, clk_i cycles per UART bit (25 MHz / 115200).
REQ-002 Parameter SRAM_NUM_INSTANCES, default 8, number of 32x512 SRAM banks.
REQ-003 Parameters ADDR_WIDTH 9, DATA_WIDTH 32, NUM_WMASKS 4: per-bank SRAM port-0 widths.
REQ-004 clk_i  in  1  sole clock; one clock, all logic on its rising edge.
REQ-005 rst_i  in  1  reset, synchronous, active-high.
REQ-006 ser_rx  in  1  UART receive line, 8N1, idle high, asynchronous to clk_i.
REQ-007 sram_csb0  out  SRAM_NUM_INSTANCES  per-bank chip select, active-low.
REQ-008 sram_web0  out  SRAM_NUM_INSTANCES  per-bank write enable, active-low.
REQ-009 sram_wmask0  out  SRAM_NUM_INSTANCES*NUM_WMASKS  flattened byte masks, bank i at [i*4+:4].
REQ-010 sram_addr0  out  SRAM_NUM_INSTANCES*ADDR_WIDTH  flattened word addresses, bank i at [i*9+:9].
REQ-011 sram_din0  out  SRAM_NUM_INSTANCES*DATA_WIDTH  flattened write data, bank i at [i*32+:32].
REQ-012 load_active_o  out  1  high while loader owns SRAM port 0; sky130_top muxes port 0 on it.
REQ-013 core_rst_o  out  1  active-high core reset; held until a load completes successfully.
REQ-014 done_o  out  1  image loaded with valid checksum.
REQ-015 err_o  out  1  framing, length or checksum error.

Function
REQ-016 Receive: 2-flop synchroniser on ser_rx; falling edge starts a frame.
REQ-017 Receive: start bit re-checked at CLK_DIV/2; if high, the frame is discarded.
REQ-018 Receive: data bits sampled LSB first at bit centres; stop bit sampled at its centre.
REQ-019 Receive: one-cycle byte strobe per frame; stop bit low flags a framing error and no valid byte.
REQ-020 Protocol: sync 0xA5, LEN_LO, LEN_HI (word count N, little-endian), N×4 data bytes (each word little-endian), one checksum byte = XOR of all data bytes.
REQ-021 FSM states: SYNC, LEN_LO, LEN_HI, DATA, WRITE, CHECK, DONE, ERROR.
REQ-022 SYNC: 0xA5 -> LEN_LO; other bytes ignored.
REQ-023 LEN_LO -> LEN_HI -> DATA on each byte; N==0 -> CHECK; N>SRAM_NUM_INSTANCES*512 -> ERROR.
REQ-024 DATA: 4th byte of a word -> WRITE.
REQ-025 WRITE lasts exactly one cycle:
  - bank b = idx[11:9] drives csb0=0, web0=0, wmask0=4'hF, addr0=idx[8:0], din0=word;
  - all other banks csb0=1, web0=1;
  - idx increments;
  - next state DATA, or CHECK if idx+1==N.
REQ-026 Outside WRITE, all csb0 and web0 are 1; addr/din/wmask hold their last values.
REQ-027 CHECK: received byte equals running XOR -> DONE, else -> ERROR.
REQ-028 A framing error in any state except SYNC, DONE or ERROR -> ERROR.
REQ-029 DONE is terminal until rst_i: done_o=1, core_rst_o=0, load_active_o=0; further bytes ignored.
REQ-030 ERROR: err_o=1, core_rst_o=1, load_active_o=0; a received 0xA5 clears err_o, resets idx and XOR, and goes to LEN_LO.
REQ-031 load_active_o=1 in LEN_LO, LEN_HI, DATA, WRITE and CHECK.
REQ-032 No backpressure needed: bytes arrive at most once per 10*CLK_DIV cycles, and WRITE takes one cycle.

Reset
REQ-033 While rst_i is high at a clock edge:
  - state SYNC; idx, XOR and byte counter 0; receiver idle;
  - csb0 and web0 all 1; wmask0, addr0, din0 0;
  - load_active_o 0, core_rst_o 1, done_o 0, err_o 0.
REQ-034 rst_i mid-frame or mid-load aborts cleanly; SRAM contents are not cleared.

Structure
REQ-035 Package sram_pkg holds SRAM_NUM_INSTANCES, ADDR_WIDTH, DATA_WIDTH, NUM_WMASKS, the SYNC_BYTE constant 0xA5 and the loader state enum; sky130_top shares it.
REQ-036 One sub-module, uart_rx_byte: synchroniser, bit timing, byte strobe, framing-error strobe.

Verification
REQ-037 CLK_DIV=4; send A5 02 00 11 22 33 44 55 66 77 88 chk=0x88 -> bank0 addr0 gets 0x44332211, addr1 gets 0x88776655, one-cycle WRITE each, then done_o=1, core_rst_o=0.
REQ-038 N=513, word 512 = 0xDEADBEEF -> write on bank1 addr0, csb0=8'b1111_1101.
REQ-039 Good image with checksum byte off by one -> err_o=1, core_rst_o stays 1; then A5 00 00 00 -> err_o=0, done_o=1.
REQ-040 Stop bit forced low on the 3rd data byte -> ERROR, no SRAM write; 0x55 sent in SYNC -> ignored, no state change.
REQ-041 LEN = 0x1001 -> ERROR immediately after LEN_HI.
REQ-042 rst_i pulsed during DATA after 2 words -> all outputs at reset values next cycle; a full reload then succeeds.

Source files
------------

// File: rtl/sram_pkg.sv
// Shared SRAM geometry, loader protocol constant and loader FSM encoding.
// Also used by sky130_top so both sides agree on bank layout.
package sram_pkg;

    localparam int SRAM_NUM_INSTANCES = 8;
    localparam int ADDR_WIDTH         = 9;
    localparam int DATA_WIDTH         = 32;
    localparam int NUM_WMASKS         = 4;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    typedef enum logic [2:0] {
        SYNC, LEN_LO, LEN_HI, DATA, WRITE, CHECK, DONE, ERROR
    } loader_state_e;

    typedef struct packed {
        logic load_active;
        logic core_rst;
        logic done;
        logic err;
    } loader_flags_t;

    // Status outputs are a pure function of the state being entered.
    function automatic loader_flags_t state_flags(input loader_state_e st);
        loader_flags_t f;
        f.load_active = st inside {LEN_LO, LEN_HI, DATA, WRITE, CHECK};
        f.core_rst    = (st != DONE);
        f.done        = (st == DONE);
        f.err         = (st == ERROR);
        return f;
    endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver: 2-flop synchroniser, mid-bit sampling, one-cycle byte
// and framing-error strobes.
module uart_rx_byte #(
    parameter int CLK_DIV = 217
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       ser_rx,
    output logic [7:0] rx_byte,
    output logic       rx_vld,
    output logic       rx_ferr
);

    localparam int HALF  = (CLK_DIV / 2 > 0) ? CLK_DIV / 2 : 1;
    localparam int CNT_W = $clog2(CLK_DIV + 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

    rx_state_e        st;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bitn;
    logic             rx_meta, rx_sync, rx_prev;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
            st      <= RX_IDLE;
            cnt     <= '0;
            bitn    <= '0;
            rx_byte <= '0;
            rx_vld  <= 1'b0;
            rx_ferr <= 1'b0;
        end else begin
            rx_meta <= ser_rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
            rx_vld  <= 1'b0;
            rx_ferr <= 1'b0;
            case (st)
                RX_IDLE: begin
                    if (rx_prev && !rx_sync) begin
                        st  <= RX_START;
                        cnt <= '0;
                    end
                end
                RX_START: begin
                    // A start bit that is high again at mid-bit was a glitch.
                    if (cnt == CNT_W'(HALF - 1)) begin
                        cnt  <= '0;
                        bitn <= '0;
                        st   <= rx_sync ? RX_IDLE : RX_DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (cnt == CNT_W'(CLK_DIV - 1)) begin
                        cnt     <= '0;
                        rx_byte <= {rx_sync, rx_byte[7:1]};
                        bitn    <= bitn + 1'b1;
                        if (bitn == 3'd7) st <= RX_STOP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (cnt == CNT_W'(CLK_DIV - 1)) begin
                        cnt     <= '0;
                        rx_vld  <= rx_sync;
                        rx_ferr <= !rx_sync;
                        st      <= RX_IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: st <= RX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/sram_uart_loader.sv
// Boot loader: receives a framed, XOR-checksummed image over UART and writes
// it word by word into the banked SRAMs through port 0, then releases core reset.
module sram_uart_loader
    import sram_pkg::loader_state_e, sram_pkg::loader_flags_t, sram_pkg::state_flags,
           sram_pkg::SYNC_BYTE, sram_pkg::SYNC, sram_pkg::LEN_LO, sram_pkg::LEN_HI,
           sram_pkg::DATA, sram_pkg::WRITE, sram_pkg::CHECK, sram_pkg::DONE, sram_pkg::ERROR;
#(
    parameter int CLK_DIV            = 217,
    parameter int SRAM_NUM_INSTANCES = sram_pkg::SRAM_NUM_INSTANCES,
    parameter int ADDR_WIDTH         = sram_pkg::ADDR_WIDTH,
    parameter int DATA_WIDTH         = sram_pkg::DATA_WIDTH,
    parameter int NUM_WMASKS         = sram_pkg::NUM_WMASKS
) (
    input  logic                                     clk_i,
    input  logic                                     rst_i,
    input  logic                                     ser_rx,
    output logic [SRAM_NUM_INSTANCES-1:0]            sram_csb0,
    output logic [SRAM_NUM_INSTANCES-1:0]            sram_web0,
    output logic [SRAM_NUM_INSTANCES*NUM_WMASKS-1:0] sram_wmask0,
    output logic [SRAM_NUM_INSTANCES*ADDR_WIDTH-1:0] sram_addr0,
    output logic [SRAM_NUM_INSTANCES*DATA_WIDTH-1:0] sram_din0,
    output logic                                     load_active_o,
    output logic                                     core_rst_o,
    output logic                                     done_o,
    output logic                                     err_o
);

    localparam int DEPTH  = SRAM_NUM_INSTANCES << ADDR_WIDTH;
    localparam int IDX_W  = $clog2(DEPTH) + 1;
    localparam int BANK_W = $clog2(SRAM_NUM_INSTANCES);
    localparam int BCNT_W = $clog2(NUM_WMASKS);

    logic [7:0] rx_byte;
    logic       rx_vld, rx_ferr;

    uart_rx_byte #(.CLK_DIV(CLK_DIV)) u_rx (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .ser_rx  (ser_rx),
        .rx_byte (rx_byte),
        .rx_vld  (rx_vld),
        .rx_ferr (rx_ferr)
    );

    loader_state_e         state;
    loader_flags_t         flags;
    logic [IDX_W-1:0]      idx, n_words;
    logic [7:0]            len_lo, xor_acc;
    logic [BCNT_W-1:0]     bcnt;
    logic [DATA_WIDTH-9:0] word_lo;

    logic [15:0]           len_full;
    logic [DATA_WIDTH-1:0] wr_word;
    logic [IDX_W-1:0]      idx_nxt;
    logic [BANK_W-1:0]     bank;

    assign len_full = {rx_byte, len_lo};
    assign wr_word  = {rx_byte, word_lo};
    assign idx_nxt  = idx + IDX_W'(1);
    assign bank     = idx[ADDR_WIDTH +: BANK_W];

    assign {load_active_o, core_rst_o, done_o, err_o} = flags;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= SYNC;
            flags       <= state_flags(SYNC);
            idx         <= '0;
            n_words     <= '0;
            len_lo      <= '0;
            xor_acc     <= '0;
            bcnt        <= '0;
            word_lo     <= '0;
            sram_csb0   <= '1;
            sram_web0   <= '1;
            sram_wmask0 <= '0;
            sram_addr0  <= '0;
            sram_din0   <= '0;
        end else begin
            // Strobes are one cycle; only the WRITE entry below pulls them low.
            sram_csb0 <= '1;
            sram_web0 <= '1;
            case (state)
                SYNC: begin
                    if (rx_vld && rx_byte == SYNC_BYTE) begin
                        state <= LEN_LO;
                        flags <= state_flags(LEN_LO);
                    end
                end
                LEN_LO: begin
                    if (rx_ferr) begin
                        state <= ERROR;
                        flags <= state_flags(ERROR);
                    end else if (rx_vld) begin
                        len_lo <= rx_byte;
                        state  <= LEN_HI;
                        flags  <= state_flags(LEN_HI);
                    end
                end
                LEN_HI: begin
                    if (rx_ferr || (rx_vld && len_full > 16'(DEPTH))) begin
                        state <= ERROR;
                        flags <= state_flags(ERROR);
                    end else if (rx_vld) begin
                        n_words <= len_full[IDX_W-1:0];
                        state   <= (len_full == '0) ? CHECK : DATA;
                        flags   <= state_flags((len_full == '0) ? CHECK : DATA);
                    end
                end
                DATA: begin
                    if (rx_ferr) begin
                        state <= ERROR;
                        flags <= state_flags(ERROR);
                    end else if (rx_vld) begin
                        word_lo <= wr_word[DATA_WIDTH-1:8];
                        xor_acc <= xor_acc ^ rx_byte;
                        bcnt    <= bcnt + 1'b1;
                        if (bcnt == BCNT_W'(NUM_WMASKS - 1)) begin
                            bcnt <= '0;
                            for (int b = 0; b < SRAM_NUM_INSTANCES; b++) begin
                                if (BANK_W'(b) == bank) begin
                                    sram_csb0[b] <= 1'b0;
                                    sram_web0[b] <= 1'b0;
                                    sram_wmask0[b*NUM_WMASKS +: NUM_WMASKS] <= '1;
                                    sram_addr0[b*ADDR_WIDTH +: ADDR_WIDTH]  <= idx[ADDR_WIDTH-1:0];
                                    sram_din0[b*DATA_WIDTH +: DATA_WIDTH]   <= wr_word;
                                end
                            end
                            state <= WRITE;
                            flags <= state_flags(WRITE);
                        end
                    end
                end
                WRITE: begin
                    idx <= idx_nxt;
                    if (rx_ferr) begin
                        state <= ERROR;
                        flags <= state_flags(ERROR);
                    end else begin
                        state <= (idx_nxt == n_words) ? CHECK : DATA;
                        flags <= state_flags((idx_nxt == n_words) ? CHECK : DATA);
                    end
                end
                CHECK: begin
                    if (rx_ferr || (rx_vld && rx_byte != xor_acc)) begin
                        state <= ERROR;
                        flags <= state_flags(ERROR);
                    end else if (rx_vld) begin
                        state <= DONE;
                        flags <= state_flags(DONE);
                    end
                end
                DONE: ;
                ERROR: begin
                    if (rx_vld && rx_byte == SYNC_BYTE) begin
                        idx     <= '0;
                        xor_acc <= '0;
                        bcnt    <= '0;
                        state   <= LEN_LO;
                        flags   <= state_flags(LEN_LO);
                    end
                end
                default: begin
                    state <= SYNC;
                    flags <= state_flags(SYNC);
                end
            endcase
        end
    end

endmodule
